// File: rtl/data_sync_capture_pkg.sv
// rtl/data_sync_capture_pkg.sv - shared defaults and pointer sizing for the enable-synchronised capture path
package data_sync_pkg;

    localparam int DEF_BUS_WIDTH = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_CNT_WIDTH = 8;

    // One extra MSB over the index width separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/data_sync_capture_if.sv
// rtl/data_sync_capture_if.sv - capture-side enable/data inputs and buffered word handshake
interface data_sync_capture_if
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

    localparam int LVL_W = ptr_width(DEPTH);

    logic                 sync_bus_enable;
    logic [BUS_WIDTH-1:0] unsync_bus;
    logic                 sync_ready;
    logic [BUS_WIDTH-1:0] sync_bus;
    logic                 sync_valid;
    logic                 enable_pulse;
    logic                 overrun;
    logic [CNT_WIDTH-1:0] overrun_count;
    logic [LVL_W-1:0]     fifo_level;

    modport master (
        input  sync_bus_enable, unsync_bus, sync_ready,
        output sync_bus, sync_valid, enable_pulse, overrun, overrun_count, fifo_level
    );

    modport slave (
        output sync_bus_enable, unsync_bus, sync_ready,
        input  sync_bus, sync_valid, enable_pulse, overrun, overrun_count, fifo_level
    );

endinterface

// File: rtl/data_sync_capture_fifo.sv
// rtl/data_sync_capture_fifo.sv - first-word-fall-through buffer for captured words
module sync_capture_fifo
    import data_sync_pkg::*;
#(
    parameter int WIDTH = DEF_BUS_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic [ptr_width(DEPTH)-1:0] level,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[PTR_W-2:0]] <= wr_data;
    end

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == PTR_W'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[PTR_W-2:0]];

endmodule

// File: rtl/data_sync_capture.sv
// rtl/data_sync_capture.sv - rising-edge capture of unsync_bus into a FIFO; DATA_SYNC_OVERRUN_CNT_EN adds the drop counter
module data_sync_capture
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input logic                clk,
    input logic                rst,
    data_sync_capture_if.master bus
);

    logic en_q, en_d;
    logic enable_pulse_q, enable_pulse_d;
    logic overrun_q, overrun_d;
    logic rise, rd, wr, drop, full, empty;

    assign rise = bus.sync_bus_enable & ~en_q;
    assign rd   = ~empty & bus.sync_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign wr   = rise & (~full | rd);
    assign drop = rise & full & ~rd;

    always_comb begin
        en_d           = bus.sync_bus_enable;
        enable_pulse_d = wr;
        overrun_d      = drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q           <= 1'b0;
            enable_pulse_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            en_q           <= en_d;
            enable_pulse_q <= enable_pulse_d;
            overrun_q      <= overrun_d;
        end
    end

    sync_capture_fifo #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_data (bus.unsync_bus),
        .rd_en   (rd),
        .rd_data (bus.sync_bus),
        .level   (bus.fifo_level),
        .full    (full),
        .empty   (empty)
    );

`ifdef DATA_SYNC_OVERRUN_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (drop && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign bus.overrun_count = cnt_q;
`else
    assign bus.overrun_count = '0;
`endif

    assign bus.sync_valid   = ~empty;
    assign bus.enable_pulse = enable_pulse_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_data_sync_capture.sv
// tb/tb_data_sync_capture.sv - scoreboard bench for data_sync_capture
module tb_data_sync_capture;
    import data_sync_pkg::*;

    localparam int BW = 8;
    localparam int DP = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_sync_capture_if #(.BUS_WIDTH(BW), .DEPTH(DP), .CNT_WIDTH(CW)) bus ();

    data_sync_capture #(.BUS_WIDTH(BW), .DEPTH(DP), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int ovr_cnt = 0;
    logic [BW-1:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef DATA_SYNC_OVERRUN_CNT_EN
        return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
`else
        return 0 * n;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (bus.enable_pulse) pulse_cnt++;
            if (bus.overrun) ovr_cnt++;
            if (bus.sync_valid && bus.sync_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got word %0h expected no valid word", bus.sync_bus);
                end else begin
                    chk("rd_data", 32'(bus.sync_bus), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [BW-1:0] d);
        bus.unsync_bus      = d;
        bus.sync_bus_enable = 1'b1;
        step();
        bus.sync_bus_enable = 1'b0;
        step();
    endtask

    task automatic drain(input int n);
        bus.sync_ready = 1'b1;
        repeat (n) step();
        bus.sync_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.sync_valid), 0);
        chk({tag, "_bus"},   32'(bus.sync_bus), 0);
        chk({tag, "_level"}, 32'(bus.fifo_level), 0);
        chk({tag, "_pulse"}, 32'(bus.enable_pulse), 0);
        chk({tag, "_ovr"},   32'(bus.overrun), 0);
        chk({tag, "_cnt"},   32'(bus.overrun_count), 0);
    endtask

    initial begin
        bus.sync_bus_enable = 1'b0;
        bus.unsync_bus      = '0;
        bus.sync_ready      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        step();
        rst = 1'b1;
        step();

        // Single capture with enable held high for five cycles
        pulse_cnt = 0;
        bus.unsync_bus      = 8'hA5;
        bus.sync_bus_enable = 1'b1;
        step();
        @(negedge clk);
        chk("single_valid", 32'(bus.sync_valid), 1);
        chk("single_bus",   32'(bus.sync_bus), 32'hA5);
        chk("single_pulse", 32'(bus.enable_pulse), 1);
        chk("single_level", 32'(bus.fifo_level), 1);
        repeat (4) step();
        bus.sync_bus_enable = 1'b0;
        step();
        @(negedge clk);
        chk("single_hold_level", 32'(bus.fifo_level), 1);
        chk("single_pulse_cnt",  32'(pulse_cnt), 1);
        sb.push_back(8'hA5);
        drain(1);
        @(negedge clk);
        chk("single_drain_level", 32'(bus.fifo_level), 0);
        chk("single_drain_bus",   32'(bus.sync_bus), 0);

        // Fill past DEPTH: fifth word dropped
        pulse_cnt = 0;
        ovr_cnt   = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= DP) sb.push_back(BW'(i));
            capture(BW'(i));
        end
        @(negedge clk);
        chk("fill_level",     32'(bus.fifo_level), DP);
        chk("fill_ovr_pulses", 32'(ovr_cnt), 1);
        chk("fill_pulses",    32'(pulse_cnt), DP);
        chk("fill_ovr_count", 32'(bus.overrun_count), 32'(exp_cnt(1)));
        drain(DP);
        @(negedge clk);
        chk("fill_drain_level", 32'(bus.fifo_level), 0);
        chk("fill_sb_empty",    32'(sb.size()), 0);

        // Full FIFO, capture and read on the same edge
        for (int i = 0; i < DP; i++) begin
            sb.push_back(BW'(8'h11 + i));
            capture(BW'(8'h11 + i));
        end
        ovr_cnt = 0;
        bus.unsync_bus      = 8'h15;
        bus.sync_bus_enable = 1'b1;
        bus.sync_ready      = 1'b1;
        sb.push_back(8'h15);
        step();
        bus.sync_bus_enable = 1'b0;
        bus.sync_ready      = 1'b0;
        step();
        @(negedge clk);
        chk("fullrw_level", 32'(bus.fifo_level), DP);
        chk("fullrw_no_ovr", 32'(ovr_cnt), 0);
        chk("fullrw_ovr_count", 32'(bus.overrun_count), 32'(exp_cnt(1)));
        drain(DP);
        @(negedge clk);
        chk("fullrw_sb_empty", 32'(sb.size()), 0);

        // Reset with three words buffered
        for (int i = 0; i < 3; i++) capture(BW'(8'h60 + i));
        @(negedge clk);
        chk("prerst_level", 32'(bus.fifo_level), 3);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_idle("midrst");
        step();
        rst = 1'b1;
        pulse_cnt = 0;
        ovr_cnt   = 0;
        repeat (2) step();
        @(negedge clk);
        chk("postrst_valid", 32'(bus.sync_valid), 0);
        chk("postrst_level", 32'(bus.fifo_level), 0);
        drain(3);

        // Counter saturation: six drops
        for (int i = 0; i < DP; i++) begin
            sb.push_back(BW'(8'h21 + i));
            capture(BW'(8'h21 + i));
        end
        for (int i = 0; i < 6; i++) capture(BW'(8'h40 + i));
        @(negedge clk);
        chk("sat_ovr_pulses", 32'(ovr_cnt), 6);
        chk("sat_ovr_count",  32'(bus.overrun_count), 32'(exp_cnt(6)));
        chk("sat_level",      32'(bus.fifo_level), DP);
        drain(DP);
        @(negedge clk);
        chk("sat_sb_empty", 32'(sb.size()), 0);

        // Streaming at maximum capture rate
        bus.sync_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.unsync_bus      = BW'(8'h30 + i);
            bus.sync_bus_enable = 1'b1;
            sb.push_back(BW'(8'h30 + i));
            step();
            @(negedge clk);
            chk("stream_valid", 32'(bus.sync_valid), 1);
            chk("stream_level_le1", 32'(bus.fifo_level <= 1), 1);
            bus.sync_bus_enable = 1'b0;
            step();
            @(negedge clk);
            chk("stream_level_gap", 32'(bus.fifo_level), 0);
        end
        bus.sync_ready = 1'b0;
        step();
        @(negedge clk);
        chk("stream_sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
